// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared types, defaults and helpers for the MMU load controller
// Purpose: controller state type, default matrix geometry, index-width helper.
// Ports: none (package).
package tpu_pkg;

  localparam int DEF_N  = 2;
  localparam int DEF_DW = 8;
  localparam int DEF_CW = 8;

  typedef enum logic [1:0] {
    LOAD,
    START,
    COMPUTE,
    RESULT
  } ctrl_state_t;

  // Width of a row-major element index for an n x n matrix (at least 1 bit).
  function automatic int idx_w(input int n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

endpackage

// File: rtl/mmu_load_ctrl_if.sv
// rtl/mmu_load_ctrl_if.sv - host-side load/readout/control bus of the MMU load controller
// Purpose: groups the host byte-load, indexed readout and run-control signals.
// Ports (slave = controller side):
//   in : load_en, load_sel_ab, load_index, in_data, out_en, out_sel, clear, reuse_b
//   out: load_ready, load_err, out_data, out_valid, busy, done
interface mmu_load_ctrl_if
  import tpu_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int DW = DEF_DW,
  parameter int CW = DEF_CW
);
  localparam int IW = idx_w(N);

  logic          load_en;
  logic          load_sel_ab;
  logic [IW-1:0] load_index;
  logic [DW-1:0] in_data;
  logic          load_ready;
  logic          load_err;
  logic          out_en;
  logic [IW-1:0] out_sel;
  logic [CW-1:0] out_data;
  logic          out_valid;
  logic          clear;
  logic          reuse_b;
  logic          busy;
  logic          done;

  modport slave (
    input  load_en, load_sel_ab, load_index, in_data, out_en, out_sel, clear, reuse_b,
    output load_ready, load_err, out_data, out_valid, busy, done
  );

  modport master (
    output load_en, load_sel_ab, load_index, in_data, out_en, out_sel, clear, reuse_b,
    input  load_ready, load_err, out_data, out_valid, busy, done
  );

endinterface

// File: rtl/load_bitmap.sv
// rtl/load_bitmap.sv - per-element "loaded" bitmap for one operand matrix
// Purpose: tracks which elements have been written since the last re-arm.
// Ports:
//   clk, rst   clock, async active-high reset
//   set_en     mark element set_idx as loaded this cycle
//   set_idx    element index (caller guarantees it is in range when set_en)
//   clr        re-arm: clear all bits
//   full_next  all bits set once this cycle's set_en is included
module load_bitmap #(
  parameter int NB = 4,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [IW-1:0] set_idx,
  input  logic          clr,
  output logic          full_next
);

  logic [NB-1:0] bits;
  logic [NB-1:0] set_mask;

  always_comb begin
    set_mask = '0;
    if (set_en) set_mask[set_idx] = 1'b1;
  end

  // Look-ahead so the completing write moves the FSM on without an idle cycle.
  assign full_next = &(bits | set_mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      bits <= '0;
    else if (clr) bits <= '0;
    else          bits <= bits | set_mask;
  end

endmodule

// File: rtl/mmu_load_ctrl.sv
// rtl/mmu_load_ctrl.sv - operand-load / result-readout controller for the NxN systolic MMU
// Purpose: byte-serial A/B load, single start pulse, result capture, registered indexed reads,
//          optional B reuse and compute timeout.
// Ports:
//   clk, rst      clock, async active-high reset
//   host          host bus (mmu_load_ctrl_if.slave)
//   a_flat/b_flat operand matrices to the array, element i at [i*DW +: DW]
//   array_start   one-cycle start pulse
//   array_done    array completion, c_flat valid while high
//   c_flat        array results, element i at [i*CW +: CW]
module mmu_load_ctrl
  import tpu_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int DW      = DEF_DW,
  parameter int CW      = DEF_CW,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  mmu_load_ctrl_if.slave    host,
  output logic [N*N*DW-1:0] a_flat,
  output logic [N*N*DW-1:0] b_flat,
  output logic              array_start,
  input  logic              array_done,
  input  logic [N*N*CW-1:0] c_flat
);

  localparam int NE = N * N;
  localparam int IW = idx_w(N);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  ctrl_state_t      state, state_n;
  logic             load_ok, rd_ok;
  logic             a_full, b_full;
  logic             clr_a, clr_b, to_hit;
  logic [TW-1:0]    tcnt;
  logic [NE*CW-1:0] rbuf;
  logic [CW-1:0]    out_data_q;
  logic             out_valid_q;
  logic             load_err_q;

  assign load_ok = host.load_en && (state == LOAD) && (int'(host.load_index) < NE);
  assign rd_ok   = host.out_en && (state == RESULT) && (int'(host.out_sel) < NE);

  load_bitmap #(.NB(NE), .IW(IW)) u_a_map (
    .clk       (clk),
    .rst       (rst),
    .set_en    (load_ok && !host.load_sel_ab),
    .set_idx   (host.load_index),
    .clr       (clr_a),
    .full_next (a_full)
  );

  load_bitmap #(.NB(NE), .IW(IW)) u_b_map (
    .clk       (clk),
    .rst       (rst),
    .set_en    (load_ok && host.load_sel_ab),
    .set_idx   (host.load_index),
    .clr       (clr_b),
    .full_next (b_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    clr_a   = 1'b0;
    clr_b   = 1'b0;
    to_hit  = 1'b0;
    case (state)
      LOAD:    if (a_full && b_full) state_n = START;
      START:   state_n = COMPUTE;
      COMPUTE: begin
        if (array_done) begin
          state_n = RESULT;
        end else if ((TIMEOUT != 0) && (int'(tcnt) == TIMEOUT - 1)) begin
          // Abandon the product; operands stay but must be fully reloaded.
          to_hit  = 1'b1;
          clr_a   = 1'b1;
          clr_b   = 1'b1;
          state_n = LOAD;
        end
      end
      RESULT: begin
        if (host.clear) begin
          clr_a   = 1'b1;
          clr_b   = !host.reuse_b;
          state_n = LOAD;
        end
      end
      default: state_n = LOAD;
    endcase
  end

  // Cycles spent in COMPUTE so far; restarts on every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   tcnt <= '0;
    else if (state != COMPUTE) tcnt <= '0;
    else                       tcnt <= tcnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_flat <= '0;
      b_flat <= '0;
    end else if (load_ok) begin
      if (host.load_sel_ab) b_flat[host.load_index*DW +: DW] <= host.in_data;
      else                  a_flat[host.load_index*DW +: DW] <= host.in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  rbuf <= '0;
    else if ((state == COMPUTE) && array_done) rbuf <= c_flat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= rd_ok ? rbuf[host.out_sel*CW +: CW] : '0;
      out_valid_q <= rd_ok;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         load_err_q <= 1'b0;
    else if ((host.load_en && !load_ok) || to_hit)   load_err_q <= 1'b1;
  end

  assign array_start     = (state == START);
  assign host.load_ready = (state == LOAD);
  assign host.busy       = (state == START) || (state == COMPUTE);
  assign host.done       = (state == RESULT);
  assign host.out_data   = out_data_q;
  assign host.out_valid  = out_valid_q;
  assign host.load_err   = load_err_q;

endmodule
